// File: rtl/prog_loader.sv
// Instruction-memory loader: streams W-bit words into consecutive addresses from 0
// and keeps the core in reset until the final word's write has committed.
module prog_loader #(
    parameter int D         = 12,
    parameter int W         = 9,
    parameter int MAX_WORDS = 2**D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [W-1:0] wr_data,
    output logic         core_reset,
    output logic         load_done,
    output logic         load_err,
    output logic [D:0]   word_count,
    output logic [W-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [D:0] LAST_IDX = (D+1)'(MAX_WORDS - 1);

    state_t state, state_next;
    logic   transfer;
    logic   at_capacity;

    assign transfer    = in_valid & in_ready;
    assign at_capacity = (word_count == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_last wins over overflow when the word at capacity is also the last one
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (transfer && in_last)          state_next = DONE;
                else if (transfer && at_capacity) state_next = ERR;
            end
            DONE, ERR: begin
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        in_ready   <= 1'b1;
                        core_reset <= 1'b1;
                        load_done  <= 1'b0;
                        load_err   <= 1'b0;
                        word_count <= '0;
                        checksum   <= '0;
                    end else if (state == DONE) begin
                        // Release one edge after the last write strobe so it commits first
                        core_reset <= 1'b0;
                    end
                end
                LOAD: begin
                    if (transfer) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= word_count[D-1:0];
                        wr_data    <= in_data;
                        word_count <= word_count + (D+1)'(1);
                        checksum   <= checksum + in_data;
                        if (in_last) begin
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end else if (at_capacity) begin
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed table-driven bench for prog_loader, built with MAX_WORDS=4 so overflow
// and capacity corners are reachable in a few cycles.
module tb_prog_loader;

    localparam int D  = 12;
    localparam int W  = 9;
    localparam int MW = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         core_reset;
    logic         load_done;
    logic         load_err;
    logic [D:0]   word_count;
    logic [W-1:0] checksum;

    int assertCount = 0;
    int failCount   = 0;

    prog_loader #(.D(D), .W(W), .MAX_WORDS(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one edge plus the outputs required just after that edge
    typedef struct {
        logic         rst;
        logic         st;
        logic         vld;
        logic [W-1:0] dat;
        logic         lst;
        logic         eRdy;
        logic         eWe;
        logic [D-1:0] eAddr;
        logic [W-1:0] eData;
        logic         eCore;
        logic         eDone;
        logic         eErr;
        logic [D:0]   eCnt;
        logic [W-1:0] eCks;
    } vec_t;

    vec_t vecs[$];

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset    = v.rst;
        start    = v.st;
        in_valid = v.vld;
        in_data  = v.dat;
        in_last  = v.lst;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkField("in_ready",   32'(in_ready),   32'(v.eRdy),  idx);
        checkField("wr_en",      32'(wr_en),      32'(v.eWe),   idx);
        checkField("wr_addr",    32'(wr_addr),    32'(v.eAddr), idx);
        checkField("wr_data",    32'(wr_data),    32'(v.eData), idx);
        checkField("core_reset", 32'(core_reset), 32'(v.eCore), idx);
        checkField("load_done",  32'(load_done),  32'(v.eDone), idx);
        checkField("load_err",   32'(load_err),   32'(v.eErr),  idx);
        checkField("word_count", 32'(word_count), 32'(v.eCnt),  idx);
        checkField("checksum",   32'(checksum),   32'(v.eCks),  idx);
    endtask

    initial begin
        vec_t v;
        bit   gotReady;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;

        //                rst st vld dat     lst rdy we addr    wdata   core done err cnt     cks
        // reset and idle
        vecs.push_back('{1, 0, 0, 9'h000, 0, 0, 0, 12'h000, 9'h000, 1, 0, 0, 13'd0, 9'h000});
        vecs.push_back('{0, 0, 0, 9'h000, 0, 0, 0, 12'h000, 9'h000, 1, 0, 0, 13'd0, 9'h000});
        vecs.push_back('{0, 1, 0, 9'h000, 0, 1, 0, 12'h000, 9'h000, 1, 0, 0, 13'd0, 9'h000});
        // back-to-back 0x1A5, 0x003, 0x1FF(last)
        vecs.push_back('{0, 0, 1, 9'h1A5, 0, 1, 1, 12'h000, 9'h1A5, 1, 0, 0, 13'd1, 9'h1A5});
        vecs.push_back('{0, 0, 1, 9'h003, 0, 1, 1, 12'h001, 9'h003, 1, 0, 0, 13'd2, 9'h1A8});
        vecs.push_back('{0, 0, 1, 9'h1FF, 1, 0, 1, 12'h002, 9'h1FF, 1, 1, 0, 13'd3, 9'h1A7});
        vecs.push_back('{0, 0, 0, 9'h000, 0, 0, 0, 12'h002, 9'h1FF, 0, 1, 0, 13'd3, 9'h1A7});
        vecs.push_back('{0, 0, 1, 9'h055, 0, 0, 0, 12'h002, 9'h1FF, 0, 1, 0, 13'd3, 9'h1A7});
        // restart from DONE, gapped valid
        vecs.push_back('{0, 1, 0, 9'h000, 0, 1, 0, 12'h002, 9'h1FF, 1, 0, 0, 13'd0, 9'h000});
        vecs.push_back('{0, 0, 1, 9'h010, 0, 1, 1, 12'h000, 9'h010, 1, 0, 0, 13'd1, 9'h010});
        vecs.push_back('{0, 0, 0, 9'h0AA, 1, 1, 0, 12'h000, 9'h010, 1, 0, 0, 13'd1, 9'h010});
        vecs.push_back('{0, 0, 1, 9'h020, 1, 0, 1, 12'h001, 9'h020, 1, 1, 0, 13'd2, 9'h030});
        vecs.push_back('{0, 0, 0, 9'h000, 0, 0, 0, 12'h001, 9'h020, 0, 1, 0, 13'd2, 9'h030});
        // overflow: four words without last, start during LOAD ignored
        vecs.push_back('{0, 1, 0, 9'h000, 0, 1, 0, 12'h001, 9'h020, 1, 0, 0, 13'd0, 9'h000});
        vecs.push_back('{0, 0, 1, 9'h001, 0, 1, 1, 12'h000, 9'h001, 1, 0, 0, 13'd1, 9'h001});
        vecs.push_back('{0, 0, 1, 9'h002, 0, 1, 1, 12'h001, 9'h002, 1, 0, 0, 13'd2, 9'h003});
        vecs.push_back('{0, 1, 1, 9'h004, 0, 1, 1, 12'h002, 9'h004, 1, 0, 0, 13'd3, 9'h007});
        vecs.push_back('{0, 0, 1, 9'h008, 0, 0, 1, 12'h003, 9'h008, 1, 0, 1, 13'd4, 9'h00F});
        vecs.push_back('{0, 0, 1, 9'h100, 0, 0, 0, 12'h003, 9'h008, 1, 0, 1, 13'd4, 9'h00F});
        vecs.push_back('{0, 0, 0, 9'h000, 0, 0, 0, 12'h003, 9'h008, 1, 0, 1, 13'd4, 9'h00F});
        // restart from ERR, last word exactly at capacity
        vecs.push_back('{0, 1, 0, 9'h000, 0, 1, 0, 12'h003, 9'h008, 1, 0, 0, 13'd0, 9'h000});
        vecs.push_back('{0, 0, 1, 9'h100, 0, 1, 1, 12'h000, 9'h100, 1, 0, 0, 13'd1, 9'h100});
        vecs.push_back('{0, 0, 1, 9'h100, 0, 1, 1, 12'h001, 9'h100, 1, 0, 0, 13'd2, 9'h000});
        vecs.push_back('{0, 0, 1, 9'h100, 0, 1, 1, 12'h002, 9'h100, 1, 0, 0, 13'd3, 9'h100});
        vecs.push_back('{0, 0, 1, 9'h0FF, 1, 0, 1, 12'h003, 9'h0FF, 1, 1, 0, 13'd4, 9'h1FF});
        vecs.push_back('{0, 0, 0, 9'h000, 0, 0, 0, 12'h003, 9'h0FF, 0, 1, 0, 13'd4, 9'h1FF});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Reset mid-load after 2 of 5 words
        applyStimulus('{0, 1, 0, 9'h000, 0, 1, 0, 12'h003, 9'h0FF, 1, 0, 0, 13'd0, 9'h000});
        v = '{0, 0, 1, 9'h011, 0, 1, 1, 12'h000, 9'h011, 1, 0, 0, 13'd1, 9'h011};
        applyStimulus(v);
        checkOutput(v, 100);
        v = '{0, 0, 1, 9'h022, 0, 1, 1, 12'h001, 9'h022, 1, 0, 0, 13'd2, 9'h033};
        applyStimulus(v);
        checkOutput(v, 101);
        v = '{1, 0, 1, 9'h033, 0, 0, 0, 12'h000, 9'h000, 1, 0, 0, 13'd0, 9'h000};
        applyStimulus(v);
        checkOutput(v, 102);
        for (int k = 0; k < 2; k++) begin
            v = '{0, 0, 1, 9'h044, 0, 0, 0, 12'h000, 9'h000, 1, 0, 0, 13'd0, 9'h000};
            applyStimulus(v);
            checkOutput(v, 103 + k);
        end

        // Restart and wait (bounded) for in_ready before sending a single last word
        applyStimulus('{0, 1, 0, 9'h000, 0, 1, 0, 12'h000, 9'h000, 1, 0, 0, 13'd0, 9'h000});
        start    = 1'b0;
        gotReady = 1'b0;
        for (int c = 0; c < 8 && !gotReady; c++) begin
            if (in_ready === 1'b1) gotReady = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkField("ready_wait", 32'(gotReady), 32'd1, 200);
        v = '{0, 0, 1, 9'h1C3, 1, 0, 1, 12'h000, 9'h1C3, 1, 1, 0, 13'd1, 9'h1C3};
        applyStimulus(v);
        checkOutput(v, 201);
        v = '{0, 0, 0, 9'h000, 0, 0, 0, 12'h000, 9'h1C3, 0, 1, 0, 13'd1, 9'h1C3};
        applyStimulus(v);
        checkOutput(v, 202);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
